// File: rtl/ahb_sramc_pkg.sv
// Shared encodings, BIST patterns and state type for the AHB SRAM controller.
// Also holds the byte-lane decode used by both the write buffer and read path.
package ahb_sramc_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [1:0] HRESP_OKAY = 2'b00;

  localparam logic [7:0] BIST_PAT_55 = 8'h55;
  localparam logic [7:0] BIST_PAT_AA = 8'hAA;

  typedef enum logic [2:0] {
    BIST_IDLE,
    BIST_W55,
    BIST_R55,
    BIST_WAA,
    BIST_RAA,
    BIST_DONE
  } bist_state_t;

  // Oversized transfers collapse to a full word; misaligned low bits are dropped.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] offs);
    case (size)
      HSIZE_BYTE: lane_mask = 4'b0001 << offs;
      HSIZE_HALF: lane_mask = offs[1] ? 4'b1100 : 4'b0011;
      default:    lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/sram_8k8.sv
// 8K x 8 synchronous single-port RAM; dout is registered and only updates on reads.
module sram_8k8
  import ahb_sramc_pkg::*;
#(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    din,
  output logic [7:0]    dout
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) mem[addr] <= din;
      else    dout <= mem[addr];
    end
  end

endmodule

// File: rtl/ahb_sramc.sv
// Zero-wait-state AHB-Lite SRAM controller: 2 banks x 4 byte lanes of 8K x 8.
// Define SRAMC_BIST_EN to include the march-style BIST engine.
module ahb_sramc
  import ahb_sramc_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int WORD_AW = 13
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic        hwrite,
  input  logic        hready,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [1:0]  htrans,
  input  logic [31:0] hwdata,
  input  logic [31:0] haddr,
  input  logic        dft_en,
  input  logic        bist_en,
  output logic        hready_resp,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata,
  output logic        bist_done,
  output logic [7:0]  bist_fail
);

  logic               ap_valid, rd_ap, wr_ap, ap_bank;
  logic [WORD_AW-1:0] ap_word;
  logic [3:0]         ap_mask;

  logic               dp_read, dp_write, dp_bank;
  logic [WORD_AW-1:0] dp_word;

  logic               wb_valid, wb_bank, wb_commit, wb_hit;
  logic [WORD_AW-1:0] wb_word;
  logic [3:0]         wb_mask;
  logic [31:0]        wb_data, wb_wdata;

  logic [31:0]        rd_merged, hrdata_q;
  logic [7:0]         sram_dout [8];

  logic               bist_act, bist_we;
  logic [WORD_AW-1:0] bist_addr;
  logic [7:0]         bist_pat;

  logic unused_bits;
  assign unused_bits = ^{hburst, haddr[31:ADDR_W]};

  assign hready_resp = 1'b1;
  assign hresp       = HRESP_OKAY;

  assign ap_valid = hsel && hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ)
                    && !dft_en && !bist_en;
  assign rd_ap    = ap_valid && !hwrite;
  assign wr_ap    = ap_valid && hwrite;
  assign ap_bank  = haddr[ADDR_W-1];
  assign ap_word  = haddr[ADDR_W-2:2];
  assign ap_mask  = lane_mask(hsize, haddr[1:0]);

  // The buffer may commit in the very cycle its data arrives, so take hwdata directly then.
  assign wb_wdata  = dp_write ? hwdata : wb_data;
  assign wb_commit = wb_valid && !rd_ap && !dft_en && !bist_en && !hresetn;
  assign wb_hit    = wb_valid && wb_bank == dp_bank && wb_word == dp_word;

  always_ff @(posedge hclk) begin
    if (hresetn) begin
      dp_read  <= 1'b0;
      dp_write <= 1'b0;
      wb_valid <= 1'b0;
      hrdata_q <= '0;
    end else begin
      dp_read  <= rd_ap;
      dp_write <= wr_ap;
      if (rd_ap) begin
        dp_bank <= ap_bank;
        dp_word <= ap_word;
      end
      if (dp_write) wb_data <= hwdata;
      if (wr_ap) begin
        wb_valid <= 1'b1;
        wb_bank  <= ap_bank;
        wb_word  <= ap_word;
        wb_mask  <= ap_mask;
      end else if (wb_commit) begin
        wb_valid <= 1'b0;
      end
      if (dp_read) hrdata_q <= rd_merged;
    end
  end

  always_comb begin
    rd_merged = dp_bank ? {sram_dout[7], sram_dout[6], sram_dout[5], sram_dout[4]}
                        : {sram_dout[3], sram_dout[2], sram_dout[1], sram_dout[0]};
    if (wb_hit) begin
      for (int l = 0; l < 4; l++) begin
        if (wb_mask[l]) rd_merged[8*l +: 8] = wb_data[8*l +: 8];
      end
    end
  end

  assign hrdata = dp_read ? rd_merged : hrdata_q;

  for (genvar g = 0; g < 8; g++) begin : g_sram
    localparam logic BANK = (g >= 4);
    localparam int   LANE = g % 4;
    logic               cs, we;
    logic [WORD_AW-1:0] addr;
    logic [7:0]         din, dout;

    // BIST owns every port; otherwise reads win and the write buffer uses idle cycles.
    always_comb begin
      cs   = 1'b0;
      we   = 1'b0;
      addr = ap_word;
      din  = wb_wdata[8*LANE +: 8];
      if (bist_act) begin
        cs   = 1'b1;
        we   = bist_we;
        addr = bist_addr;
        din  = bist_pat;
      end else if (rd_ap && ap_bank == BANK) begin
        cs = 1'b1;
      end else if (wb_commit && wb_bank == BANK && wb_mask[LANE]) begin
        cs   = 1'b1;
        we   = 1'b1;
        addr = wb_word;
      end
    end

    sram_8k8 #(.AW(WORD_AW)) u_sram (
      .clk  (hclk),
      .cs   (cs),
      .we   (we),
      .addr (addr),
      .din  (din),
      .dout (dout)
    );

    assign sram_dout[g] = dout;
  end

`ifdef SRAMC_BIST_EN
  bist_state_t bist_state;
  logic        cmp_valid;
  logic [7:0]  cmp_pat;

  assign bist_act = !dft_en && (bist_state == BIST_W55 || bist_state == BIST_R55 ||
                                bist_state == BIST_WAA || bist_state == BIST_RAA);
  assign bist_we  = bist_state == BIST_W55 || bist_state == BIST_WAA;
  assign bist_pat = (bist_state == BIST_W55 || bist_state == BIST_R55) ? BIST_PAT_55 : BIST_PAT_AA;

  // Read data lands one cycle after the read state issues it, hence the compare pipeline.
  always_ff @(posedge hclk) begin
    if (hresetn) begin
      bist_state <= BIST_IDLE;
      bist_addr  <= '0;
      cmp_valid  <= 1'b0;
      cmp_pat    <= '0;
      bist_done  <= 1'b0;
      bist_fail  <= '0;
    end else if (!bist_en) begin
      bist_state <= BIST_IDLE;
      bist_addr  <= '0;
      cmp_valid  <= 1'b0;
      bist_done  <= 1'b0;
    end else if (!dft_en) begin
      cmp_valid <= bist_state == BIST_R55 || bist_state == BIST_RAA;
      cmp_pat   <= bist_pat;
      bist_done <= bist_state == BIST_DONE;
      if (cmp_valid) begin
        for (int i = 0; i < 8; i++) begin
          if (sram_dout[i] != cmp_pat) bist_fail[i] <= 1'b1;
        end
      end
      case (bist_state)
        BIST_IDLE: begin
          bist_state <= BIST_W55;
          bist_addr  <= '0;
          bist_fail  <= '0;
        end
        BIST_W55: begin
          bist_addr <= bist_addr + 1'b1;
          if (&bist_addr) bist_state <= BIST_R55;
        end
        BIST_R55: begin
          bist_addr <= bist_addr + 1'b1;
          if (&bist_addr) bist_state <= BIST_WAA;
        end
        BIST_WAA: begin
          bist_addr <= bist_addr + 1'b1;
          if (&bist_addr) bist_state <= BIST_RAA;
        end
        BIST_RAA: begin
          bist_addr <= bist_addr + 1'b1;
          if (&bist_addr) bist_state <= BIST_DONE;
        end
        default: bist_state <= BIST_DONE;
      endcase
    end
  end
`else
  assign bist_act  = 1'b0;
  assign bist_we   = 1'b0;
  assign bist_addr = '0;
  assign bist_pat  = '0;
  assign bist_done = 1'b0;
  assign bist_fail = '0;
`endif

endmodule

// File: tb/tb_ahb_sramc.sv
// Randomized bench for ahb_sramc against a byte-array memory model in program order.
// With SRAMC_BIST_EN defined it also runs the BIST scenarios.
`timescale 1ns/1ps
module tb_ahb_sramc;
  import ahb_sramc_pkg::*;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel = 1'b0, hwrite = 1'b0, hready = 1'b1;
  logic [2:0]  hsize = 3'd0, hburst = 3'd0;
  logic [1:0]  htrans = 2'b00;
  logic [31:0] hwdata = '0, haddr = '0;
  logic        dft_en = 1'b0, bist_en = 1'b0;
  logic        hready_resp;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic        bist_done;
  logic [7:0]  bist_fail;

  always #5 hclk = ~hclk;

  ahb_sramc dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .hsel        (hsel),
    .hwrite      (hwrite),
    .hready      (hready),
    .hsize       (hsize),
    .hburst      (hburst),
    .htrans      (htrans),
    .hwdata      (hwdata),
    .haddr       (haddr),
    .dft_en      (dft_en),
    .bist_en     (bist_en),
    .hready_resp (hready_resp),
    .hresp       (hresp),
    .hrdata      (hrdata),
    .bist_done   (bist_done),
    .bist_fail   (bist_fail)
  );

  int          n_compared = 0;
  int          n_mismatched = 0;
  bit          chk_en = 1'b0;
  logic [31:0] exp_hrdata = '0;
  logic [7:0]  mdl [0:65535];
  bit          prev_wr = 1'b0, prev_rd = 1'b0;
  logic [31:0] next_hwdata = '0, pend_rd = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelWord(input logic [15:0] a);
    logic [15:0] b;
    b = {a[15:2], 2'b00};
    modelWord = {mdl[b + 16'd3], mdl[b + 16'd2], mdl[b + 16'd1], mdl[b]};
  endfunction

  // Transfer width is 2**size bytes (capped at 4), starting at the aligned offset.
  function automatic void modelWrite(input logic [2:0] size, input logic [15:0] a,
                                     input logic [31:0] d);
    int nbytes, first;
    nbytes = (size > 3'd2) ? 4 : (1 << size);
    first  = (int'(a[1:0]) / nbytes) * nbytes;
    for (int k = first; k < first + nbytes; k++)
      mdl[{a[15:2], 2'b00} + 16'(k)] = d[8*k +: 8];
  endfunction

  task automatic applyStimulus(input bit sel, input bit rdy, input bit wr, input logic [1:0] trans,
                               input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit dft);
    bit accepted;
    @(posedge hclk);
    #1;
    hwdata = prev_wr ? next_hwdata : $urandom;
    if (prev_rd) exp_hrdata = pend_rd;
    hsel = sel; hready = rdy; hwrite = wr; htrans = trans; hsize = size; haddr = addr;
    hburst = 3'($urandom); dft_en = dft;
    accepted = sel && rdy && trans[1] && !dft && !bist_en;
    prev_wr = accepted && wr;
    prev_rd = accepted && !wr;
    if (prev_wr) begin
      modelWrite(size, addr[15:0], wdata);
      next_hwdata = wdata;
    end
    if (prev_rd) pend_rd = modelWord(addr[15:0]);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, HTRANS_IDLE, 3'd0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic writeAt(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] d);
    applyStimulus(1'b1, 1'b1, 1'b1, HTRANS_NONSEQ, size, addr, d, 1'b0);
  endtask

  task automatic expectRead(input string name, input logic [31:0] addr, input logic [31:0] lit);
    applyStimulus(1'b1, 1'b1, 1'b0, HTRANS_NONSEQ, HSIZE_WORD, addr, 32'h0, 1'b0);
    idleCycle();
    @(negedge hclk);
    checkOutput(name, hrdata, lit);
  endtask

  task automatic doReset(input int n);
    chk_en = 1'b0;
    @(posedge hclk);
    #1;
    if (prev_wr) hwdata = next_hwdata;
    hresetn = 1'b1; hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; dft_en = 1'b0;
    repeat (n - 1) @(posedge hclk);
    #1;
    hresetn = 1'b0;
    prev_wr = 1'b0; prev_rd = 1'b0;
    exp_hrdata = '0;
  endtask

  always @(negedge hclk) begin
    if (chk_en) begin
      checkOutput("hrdata", hrdata, exp_hrdata);
      checkOutput("hready_resp", 32'(hready_resp), 32'd1);
      checkOutput("hresp", 32'(hresp), 32'(HRESP_OKAY));
      checkOutput("bist_flags", {23'd0, bist_done, bist_fail}, 32'd0);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    doReset(10);
    @(negedge hclk);
    checkOutput("rst_hrdata", hrdata, 32'h0);
    checkOutput("rst_hready_resp", 32'(hready_resp), 32'd1);
    checkOutput("rst_hresp", 32'(hresp), 32'd0);
    checkOutput("rst_bist_done", 32'(bist_done), 32'd0);
    checkOutput("rst_bist_fail", 32'(bist_fail), 32'd0);
    chk_en = 1'b1;

    $display("[TB] directed transfers");
    writeAt(HSIZE_WORD, 32'h0000_0050, 32'hA0B0C0D0);
    expectRead("bank0_word", 32'h0000_0050, 32'hA0B0C0D0);
    writeAt(HSIZE_WORD, 32'h0000_F010, 32'h0A0B0C0D);
    expectRead("bank1_word", 32'h0000_F010, 32'h0A0B0C0D);
    expectRead("bank0_kept", 32'h0000_0050, 32'hA0B0C0D0);

    writeAt(HSIZE_WORD, 32'h0000_0100, 32'h11223344);
    writeAt(HSIZE_BYTE, 32'h0000_0102, 32'h00EE0000);
    writeAt(HSIZE_HALF, 32'h0000_0100, 32'h00005566);
    expectRead("byte_half_merge", 32'h0000_0100, 32'h11EE5566);

    writeAt(HSIZE_WORD, 32'h0000_0040, 32'hDEADBEEF);
    expectRead("fwd_word", 32'h0000_0040, 32'hDEADBEEF);
    writeAt(HSIZE_WORD, 32'h0000_0044, 32'h12345678);
    writeAt(HSIZE_BYTE, 32'h0000_0045, 32'h0000AB00);
    expectRead("fwd_byte_lane", 32'h0000_0044, 32'h1234AB78);

    applyStimulus(1'b1, 1'b1, 1'b1, HTRANS_BUSY, HSIZE_WORD, 32'h40, 32'h0BAD0001, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, HTRANS_IDLE, HSIZE_WORD, 32'h40, 32'h0BAD0002, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, HTRANS_NONSEQ, HSIZE_WORD, 32'h40, 32'h0BAD0003, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, HTRANS_NONSEQ, HSIZE_WORD, 32'h40, 32'h0BAD0004, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, HTRANS_NONSEQ, HSIZE_WORD, 32'h40, 32'h0BAD0005, 1'b1);
`ifndef SRAMC_BIST_EN
    bist_en = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, HTRANS_NONSEQ, HSIZE_WORD, 32'h40, 32'h0BAD0006, 1'b0);
    idleCycle();
    bist_en = 1'b0;
`endif
    expectRead("ignored_writes", 32'h0000_0040, 32'hDEADBEEF);

    writeAt(HSIZE_WORD, 32'h0000_0060, 32'h11111111);
    idleCycle();
    writeAt(HSIZE_WORD, 32'h0000_0060, 32'h22222222);
    doReset(2);
    modelWrite(HSIZE_WORD, 16'h0060, 32'h11111111);
    chk_en = 1'b1;
    expectRead("reset_discards_wb", 32'h0000_0060, 32'h11111111);

    $display("[TB] randomized traffic");
    for (int b = 0; b < 2; b++)
      for (int w = 0; w < 8; w++)
        writeAt(HSIZE_WORD, {16'h0, 1'(b), 10'd0, 3'(w), 2'b00}, $urandom);
    for (int c = 0; c < 4000; c++) begin
      bit          quiet, rdy, dft, sel, wr;
      logic [1:0]  trans;
      logic [2:0]  sz;
      logic [31:0] addr;
      quiet = !(prev_wr || prev_rd);
      rdy   = quiet ? ($urandom_range(0, 9) != 0) : 1'b1;
      dft   = quiet ? ($urandom_range(0, 15) == 0) : 1'b0;
      sel   = $urandom_range(0, 7) != 0;
      trans = 2'($urandom_range(0, 3));
      wr    = 1'($urandom_range(0, 1));
      sz    = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      addr  = {16'($urandom), 1'($urandom), 10'd0, 3'($urandom), 2'($urandom)};
      applyStimulus(sel, rdy, wr, trans, sz, addr, $urandom, dft);
    end
    idleCycle();
    idleCycle();

`ifdef SRAMC_BIST_EN
    begin
      int cyc;
      $display("[TB] BIST runs");
      chk_en = 1'b0;
      @(posedge hclk);
      #1 bist_en = 1'b1;
      cyc = 0;
      while (bist_done !== 1'b1 && cyc < 40000) begin @(posedge hclk); #1; cyc++; end
      checkOutput("bist_done_rise", 32'(bist_done), 32'd1);
      checkOutput("bist_cycles_in_range", 32'(cyc >= 32760 && cyc <= 32780), 32'd1);
      checkOutput("bist_clean", 32'(bist_fail), 32'h0);
      bist_en = 1'b0;
      repeat (2) @(posedge hclk);
      #1;
      checkOutput("bist_done_clear", 32'(bist_done), 32'd0);
      force dut.g_sram[5].u_sram.dout = 8'h55;
      bist_en = 1'b1;
      cyc = 0;
      while (bist_done !== 1'b1 && cyc < 40000) begin @(posedge hclk); #1; cyc++; end
      checkOutput("bist_done_rise2", 32'(bist_done), 32'd1);
      checkOutput("bist_stuck_sram5", 32'(bist_fail), 32'h20);
      release dut.g_sram[5].u_sram.dout;
      bist_en = 1'b0;
    end
`endif

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
